// File: rtl/opll_pkg.sv
// opll_pkg: shared decode constants and helpers for the OPLL register interface.
//   DEC_MASK / DEC_IDX / DEC_DAT : CPU address decode (masked compare)
//   decode_addr()                : classifies a CPU address as index/data/none
//   idx_valid()                  : true for register indices implemented by the OPLL core
package opll_pkg;

    localparam logic [15:0] DEC_MASK = 16'hF030;
    localparam logic [15:0] DEC_IDX  = 16'h9010;
    localparam logic [15:0] DEC_DAT  = 16'h9030;

    localparam int IDX_W   = 6;
    localparam int DAT_W   = 8;
    localparam int ENTRY_W = IDX_W + DAT_W;

    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        CMD_IDX  = 2'd1,
        CMD_DAT  = 2'd2
    } cpu_cmd_t;

    function automatic cpu_cmd_t decode_addr(input logic [15:0] addr);
        logic [15:0] masked;
        masked = addr & DEC_MASK;
        if (masked == DEC_IDX) return CMD_IDX;
        if (masked == DEC_DAT) return CMD_DAT;
        return CMD_NONE;
    endfunction

    // Implemented ranges: 0x00-0x07, then 0x?0-0x?5 in each upper 16-entry bank.
    function automatic logic idx_valid(input logic [IDX_W-1:0] idx);
        if (idx[5:4] == 2'b00) return !idx[3];
        return idx[3:0] <= 4'd5;
    endfunction

endpackage

// File: rtl/opll_reg_if_if.sv
// opll_reg_if_if: CPU write strobe bus plus the register-write handshake to the synth core.
//   master : CPU / synth-core side (drives cpu_*, reg_ready)
//   slave  : opll_reg_if side (drives reg_valid, reg_addr, reg_data)
interface opll_reg_if_if;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dat;
    logic        reg_valid;
    logic        reg_ready;
    logic [5:0]  reg_addr;
    logic [7:0]  reg_data;

    modport master (
        output cpu_we, cpu_addr, cpu_dat, reg_ready,
        input  reg_valid, reg_addr, reg_data
    );

    modport slave (
        input  cpu_we, cpu_addr, cpu_dat, reg_ready,
        output reg_valid, reg_addr, reg_data
    );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, no output bypass.
//   clk, rst        : clock, synchronous active-high reset
//   push/din        : write request (ignored when full unless popping the same cycle)
//   pop/dout        : read request (ignored when empty), dout shows the head entry
//   full/empty/count: occupancy
module sync_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_pop;
    logic             w_push;

    assign full   = (r_count == CNT_W'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign dout   = r_mem[r_rd_ptr];
    assign w_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a full-queue push needs.
    assign w_push = push && (!full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/opll_reg_if.sv
// opll_reg_if: CPU-facing OPLL register port. Index/data writes are decoded, valid
// data writes are queued for the synth core (paced by WR_GAP) and mirrored in a
// 64x8 shadow file the CPU side can read back.
//   clk, map_rst         : clock, synchronous active-high reset
//   bus (slave)          : cpu_we/cpu_addr/cpu_dat in, reg_valid/reg_addr/reg_data out, reg_ready in
//   ss_addr / ss_rdat    : combinational shadow read
//   idx_latch            : currently latched register index
//   ovf                  : sticky, a valid data write was dropped on a full queue
//   q_count              : queue occupancy
module opll_reg_if
    import opll_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int WR_GAP     = 84
) (
    input  logic                        clk,
    input  logic                        map_rst,
    opll_reg_if_if.slave                bus,
    input  logic [5:0]                  ss_addr,
    output logic [7:0]                  ss_rdat,
    output logic [5:0]                  idx_latch,
    output logic                        ovf,
    output logic [$clog2(FIFO_DEPTH):0] q_count
);
    localparam int GAP_W = $clog2(WR_GAP + 1);

    logic [IDX_W-1:0]   r_idx;
    logic               r_ovf;
    logic [GAP_W-1:0]   r_gap;
    logic [DAT_W-1:0]   r_shadow [64];

    cpu_cmd_t           w_cmd;
    logic               w_dat_wr;
    logic               w_valid;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [ENTRY_W-1:0] w_head;

    assign w_cmd    = bus.cpu_we ? decode_addr(bus.cpu_addr) : CMD_NONE;
    assign w_dat_wr = (w_cmd == CMD_DAT) && idx_valid(r_idx);
    // No bypass: reg_valid only depends on registered queue/gap state.
    assign w_valid  = !w_empty && (r_gap == '0);
    assign w_pop    = w_valid && bus.reg_ready;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (map_rst),
        .push  (w_dat_wr),
        .din   ({r_idx, bus.cpu_dat}),
        .pop   (w_pop),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (q_count)
    );

    always_ff @(posedge clk) begin
        if (map_rst) begin
            r_idx <= '0;
            r_ovf <= 1'b0;
            r_gap <= '0;
            for (int i = 0; i < 64; i++) r_shadow[i] <= '0;
        end else begin
            if (w_cmd == CMD_IDX) r_idx <= bus.cpu_dat[IDX_W-1:0];
            // Shadow tracks every valid data write, even one the full queue drops.
            if (w_dat_wr) r_shadow[r_idx] <= bus.cpu_dat;
            if (w_dat_wr && w_full && !w_pop) r_ovf <= 1'b1;
            if (w_pop)
                r_gap <= GAP_W'(WR_GAP - 1);
            else if (r_gap != '0)
                r_gap <= r_gap - 1'b1;
        end
    end

    assign bus.reg_valid = w_valid;
    assign bus.reg_addr  = w_head[ENTRY_W-1:DAT_W];
    assign bus.reg_data  = w_head[DAT_W-1:0];
    assign ss_rdat       = r_shadow[ss_addr];
    assign idx_latch     = r_idx;
    assign ovf           = r_ovf;
endmodule

// File: tb/tb_opll_reg_if.sv
module tb_opll_reg_if;
    localparam int DEPTH = 4;
    localparam int GAP   = 84;

    logic       clk = 1'b0;
    logic       map_rst;
    logic [5:0] ss_addr;
    logic [7:0] ss_rdat;
    logic [5:0] idx_latch;
    logic       ovf;
    logic [2:0] q_count;

    int n_checks = 0;
    int n_errors = 0;

    opll_reg_if_if bus ();

    opll_reg_if #(.FIFO_DEPTH(DEPTH), .WR_GAP(GAP)) dut (
        .clk       (clk),
        .map_rst   (map_rst),
        .bus       (bus.slave),
        .ss_addr   (ss_addr),
        .ss_rdat   (ss_rdat),
        .idx_latch (idx_latch),
        .ovf       (ovf),
        .q_count   (q_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  dat;
        logic [5:0]  ss;
        logic [5:0]  e_idx;
        logic [2:0]  e_cnt;
        logic        e_ovf;
        logic [7:0]  e_ss;
    } vec_t;

    vec_t tbl [16];

    // reference model state
    logic [13:0] mq [$];
    logic [7:0]  m_shadow [64];
    logic [5:0]  m_idx;
    logic        m_ovf;
    int          m_cyc;
    int          m_last_pop;

    task automatic chk(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        map_rst = 1'b1;
        bus.cpu_we = 1'b0;
        bus.reg_ready = 1'b0;
        step();
        map_rst = 1'b0;
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
        bus.cpu_we = 1'b1;
        bus.cpu_addr = a;
        bus.cpu_dat = d;
        step();
        bus.cpu_we = 1'b0;
    endtask

    function automatic logic m_idx_ok(input int i);
        return (i <= 7) || (i >= 16 && i <= 21) || (i >= 32 && i <= 37) || (i >= 48 && i <= 53);
    endfunction

    task automatic m_reset();
        mq.delete();
        for (int i = 0; i < 64; i++) m_shadow[i] = 8'h00;
        m_idx = 6'h00;
        m_ovf = 1'b0;
        m_last_pop = -100000;
    endtask

    initial begin
        int t, npop, nz;
        int pop_t [5];
        int pop_d [5];
        logic m_valid, pop, full;
        logic [15:0] a, dec;

        map_rst = 1'b0;
        ss_addr = 6'h00;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = 16'h0000;
        bus.cpu_dat = 8'h00;
        bus.reg_ready = 1'b0;

        tbl[0]  = '{1'b1, 16'h9010, 8'h10, 6'h10, 6'h10, 3'd0, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 16'h9030, 8'hAB, 6'h10, 6'h10, 3'd1, 1'b0, 8'hAB};
        tbl[2]  = '{1'b1, 16'h9011, 8'h05, 6'h05, 6'h05, 3'd1, 1'b0, 8'h00};
        tbl[3]  = '{1'b1, 16'h9031, 8'h66, 6'h05, 6'h05, 3'd2, 1'b0, 8'h66};
        tbl[4]  = '{1'b1, 16'h9020, 8'h3F, 6'h05, 6'h05, 3'd2, 1'b0, 8'h66};
        tbl[5]  = '{1'b0, 16'h9030, 8'h11, 6'h05, 6'h05, 3'd2, 1'b0, 8'h66};
        tbl[6]  = '{1'b0, 16'h9010, 8'h07, 6'h05, 6'h05, 3'd2, 1'b0, 8'h66};
        tbl[7]  = '{1'b1, 16'h9010, 8'h0A, 6'h0A, 6'h0A, 3'd2, 1'b0, 8'h00};
        tbl[8]  = '{1'b1, 16'h9030, 8'h55, 6'h0A, 6'h0A, 3'd2, 1'b0, 8'h00};
        tbl[9]  = '{1'b1, 16'h8010, 8'h21, 6'h0A, 6'h0A, 3'd2, 1'b0, 8'h00};
        tbl[10] = '{1'b1, 16'h9010, 8'hE1, 6'h21, 6'h21, 3'd2, 1'b0, 8'h00};
        tbl[11] = '{1'b1, 16'h9030, 8'h77, 6'h21, 6'h21, 3'd3, 1'b0, 8'h77};
        tbl[12] = '{1'b1, 16'h9030, 8'h78, 6'h21, 6'h21, 3'd4, 1'b0, 8'h78};
        tbl[13] = '{1'b1, 16'h9030, 8'h79, 6'h21, 6'h21, 3'd4, 1'b1, 8'h79};
        tbl[14] = '{1'b1, 16'h9010, 8'h36, 6'h36, 6'h36, 3'd4, 1'b1, 8'h00};
        tbl[15] = '{1'b1, 16'h9030, 8'h12, 6'h36, 6'h36, 3'd4, 1'b1, 8'h00};

        // ---- reset state
        do_reset();
        chk("rst_valid", int'(bus.reg_valid), 0);
        chk("rst_idx", int'(idx_latch), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_cnt", int'(q_count), 0);

        // ---- table: decode, aliases, invalid index, full-queue drop
        for (int i = 0; i < 16; i++) begin
            bus.cpu_we = tbl[i].we;
            bus.cpu_addr = tbl[i].addr;
            bus.cpu_dat = tbl[i].dat;
            step();
            bus.cpu_we = 1'b0;
            ss_addr = tbl[i].ss;
            #1;
            chk($sformatf("tbl%0d_idx", i), int'(idx_latch), int'(tbl[i].e_idx));
            chk($sformatf("tbl%0d_cnt", i), int'(q_count), int'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d_ovf", i), int'(ovf), int'(tbl[i].e_ovf));
            chk($sformatf("tbl%0d_ss", i), int'(ss_rdat), int'(tbl[i].e_ss));
            chk($sformatf("tbl%0d_valid", i), int'(bus.reg_valid), int'(tbl[i].e_cnt != 0));
        end

        // ---- single write/pop
        do_reset();
        cpu_wr(16'h9010, 8'h10);
        cpu_wr(16'h9030, 8'hAB);
        bus.reg_ready = 1'b1;
        t = 0;
        while (!bus.reg_valid && t < 10) begin step(); t++; end
        chk("one_valid", int'(bus.reg_valid), 1);
        chk("one_addr", int'(bus.reg_addr), 'h10);
        chk("one_data", int'(bus.reg_data), 'hAB);
        step();
        chk("one_after", int'(bus.reg_valid), 0);
        ss_addr = 6'h10;
        #1;
        chk("one_ss", int'(ss_rdat), 'hAB);
        bus.reg_ready = 1'b0;

        // ---- overflow then paced drain
        do_reset();
        cpu_wr(16'h9010, 8'h01);
        for (int i = 0; i < 5; i++) cpu_wr(16'h9030, 8'(8'h11 + i));
        ss_addr = 6'h01;
        #1;
        chk("ovf_cnt", int'(q_count), 4);
        chk("ovf_flag", int'(ovf), 1);
        chk("ovf_ss", int'(ss_rdat), 'h15);
        bus.reg_ready = 1'b1;
        t = 0; npop = 0;
        while (npop < 4 && t < 500) begin
            if (bus.reg_valid) begin pop_t[npop] = t; pop_d[npop] = int'(bus.reg_data); npop++; end
            step(); t++;
        end
        chk("drain_pops", npop, 4);
        for (int i = 0; i < npop; i++) chk($sformatf("drain_d%0d", i), pop_d[i], 'h11 + i);
        for (int i = 1; i < npop; i++) chk($sformatf("drain_gap%0d", i), pop_t[i] - pop_t[i-1], GAP);
        chk("drain_cnt", int'(q_count), 0);
        bus.reg_ready = 1'b0;

        // ---- full queue, push coincident with pop
        do_reset();
        cpu_wr(16'h9010, 8'h02);
        for (int i = 0; i < 4; i++) cpu_wr(16'h9030, 8'(8'h21 + i));
        bus.reg_ready = 1'b1;
        bus.cpu_we = 1'b1; bus.cpu_addr = 16'h9030; bus.cpu_dat = 8'h99;
        #1;
        chk("pp_valid", int'(bus.reg_valid), 1);
        chk("pp_head", int'(bus.reg_data), 'h21);
        step();
        bus.cpu_we = 1'b0;
        chk("pp_cnt", int'(q_count), 4);
        chk("pp_ovf", int'(ovf), 0);
        t = 0; npop = 0;
        while (npop < 4 && t < 500) begin
            if (bus.reg_valid) begin pop_d[npop] = int'(bus.reg_data); npop++; end
            step(); t++;
        end
        chk("pp_pops", npop, 4);
        chk("pp_d1", pop_d[0], 'h22);
        chk("pp_last", pop_d[3], 'h99);
        bus.reg_ready = 1'b0;

        // ---- invalid index
        do_reset();
        cpu_wr(16'h9010, 8'h0A);
        cpu_wr(16'h9030, 8'h55);
        step(); step();
        ss_addr = 6'h0A;
        #1;
        chk("inv_valid", int'(bus.reg_valid), 0);
        chk("inv_ss", int'(ss_rdat), 0);
        chk("inv_ovf", int'(ovf), 0);

        // ---- reset mid-transfer
        do_reset();
        cpu_wr(16'h9010, 8'h03);
        for (int i = 0; i < 5; i++) cpu_wr(16'h9030, 8'(8'h31 + i));
        bus.reg_ready = 1'b1;
        step();
        bus.reg_ready = 1'b0;
        chk("mr_cnt3", int'(q_count), 3);
        for (int i = 0; i < 43; i++) step();
        map_rst = 1'b1;
        bus.reg_ready = 1'b1;
        bus.cpu_we = 1'b1; bus.cpu_addr = 16'h9030; bus.cpu_dat = 8'hEE;
        step();
        map_rst = 1'b0; bus.cpu_we = 1'b0; bus.reg_ready = 1'b0;
        chk("mr_valid", int'(bus.reg_valid), 0);
        chk("mr_cnt", int'(q_count), 0);
        chk("mr_ovf", int'(ovf), 0);
        chk("mr_idx", int'(idx_latch), 0);
        nz = 0;
        for (int i = 0; i < 64; i++) begin
            ss_addr = 6'(i);
            #1;
            if (ss_rdat != 8'h00) nz++;
        end
        chk("mr_ss_nonzero", nz, 0);
        cpu_wr(16'h9010, 8'h04);
        bus.reg_ready = 1'b1;
        cpu_wr(16'h9030, 8'h42);
        chk("mr_nogap_valid", int'(bus.reg_valid), 1);
        chk("mr_nogap_addr", int'(bus.reg_addr), 4);
        chk("mr_nogap_data", int'(bus.reg_data), 'h42);
        step();
        chk("mr_nogap_cnt", int'(q_count), 0);
        bus.reg_ready = 1'b0;

        // ---- randomized against the reference model
        do_reset();
        m_reset();
        m_cyc = 0;
        for (int c = 0; c < 3000; c++) begin
            map_rst = ($urandom_range(0, 499) == 0);
            bus.cpu_we = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 5))
                0: a = 16'h9010;
                1: a = 16'h9030;
                2: a = 16'h9011;
                3: a = 16'h9031;
                4: a = 16'h9020;
                default: a = 16'($urandom);
            endcase
            bus.cpu_addr = a;
            bus.cpu_dat = 8'($urandom);
            bus.reg_ready = 1'($urandom_range(0, 1));
            ss_addr = 6'($urandom);
            #1;
            m_valid = (mq.size() > 0) && (m_cyc - m_last_pop >= GAP);
            chk("rnd_valid", int'(bus.reg_valid), int'(m_valid));
            if (m_valid) begin
                chk("rnd_addr", int'(bus.reg_addr), int'(mq[0][13:8]));
                chk("rnd_data", int'(bus.reg_data), int'(mq[0][7:0]));
            end
            chk("rnd_ovf", int'(ovf), int'(m_ovf));
            chk("rnd_idx", int'(idx_latch), int'(m_idx));
            chk("rnd_cnt", int'(q_count), mq.size());
            chk("rnd_ss", int'(ss_rdat), int'(m_shadow[ss_addr]));
            if (map_rst) begin
                m_reset();
            end else begin
                pop = m_valid && bus.reg_ready;
                full = (mq.size() == DEPTH);
                if (pop) begin
                    void'(mq.pop_front());
                    m_last_pop = m_cyc;
                end
                dec = a & 16'hF030;
                if (bus.cpu_we && dec == 16'h9010) m_idx = bus.cpu_dat[5:0];
                else if (bus.cpu_we && dec == 16'h9030 && m_idx_ok(int'(m_idx))) begin
                    m_shadow[m_idx] = bus.cpu_dat;
                    if (!full || pop) mq.push_back({m_idx, bus.cpu_dat});
                    else m_ovf = 1'b1;
                end
            end
            m_cyc++;
            step();
        end
        map_rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/opll_reg_if.md
OPLL_REG_IF -- requirements
Module: opll_reg_if

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, write-queue depth in entries (power of two, 2..16).
REQ-002 SHALL have parameter WR_GAP, default 84, minimum clk cycles between two successive pops to the synth core.
REQ-003 SHALL have clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have map_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have cpu_we  input  1  one-clk pulse per CPU write, already synchronised to clk.
REQ-006 SHALL have cpu_addr  input  16  CPU address qualified by cpu_we.
REQ-007 SHALL have cpu_dat  input  8  CPU write data qualified by cpu_we.
REQ-008 SHALL have reg_valid  output  1  queued register write available to the synth core.
REQ-009 SHALL have reg_ready  input  1  synth core accepts the write when high with reg_valid.
REQ-010 SHALL have reg_addr  output  6  OPLL register index of the head entry.
REQ-011 SHALL have reg_data  output  8  OPLL register data of the head entry.
REQ-012 SHALL have ss_addr  input  6  shadow-register read index.
REQ-013 SHALL have ss_rdat  output  8  shadow register at ss_addr, combinational.
REQ-014 SHALL have idx_latch  output  6  current latched register index.
REQ-015 SHALL have ovf  output  1  sticky flag: a write was dropped on a full queue.

Function
REQ-016 SHALL decode (cpu_addr AND 16'hF030) == 16'h9010 as index write: idx_latch <= cpu_dat[5:0].
REQ-017 SHALL decode (cpu_addr AND 16'hF030) == 16'h9030 as data write: push {idx_latch, cpu_dat} into queue.
REQ-018 SHALL treat indices 0x00-0x07, 0x10-0x15, 0x20-0x25, 0x30-0x35 as valid; data writes to other indices SHALL be dropped (no push, no shadow update, ovf unaffected).
REQ-019 SHALL update shadow[idx_latch] <= cpu_dat in the same cycle a valid data write is accepted into the queue.
REQ-020 SHALL present reg_valid only when queue non-empty AND gap counter is zero; reg_addr/reg_data SHALL hold head entry, stable while reg_valid and !reg_ready.
REQ-021 SHALL pop on reg_valid & reg_ready, then load gap counter with WR_GAP-1; counter decrements to 0 each cycle; next reg_valid no earlier than WR_GAP cycles after the previous pop.
REQ-022 Push on full queue SHALL be dropped, set ovf, and still update shadow (CPU view preserved).
REQ-023 Simultaneous push and pop on full queue SHALL accept the push (pop frees slot), ovf unchanged.
REQ-024 Simultaneous push and pop on non-empty, non-full queue SHALL keep count constant; on empty queue, push SHALL NOT bypass to output in the same cycle (reg_valid rises next cycle earliest).
REQ-025 Read/write pointers SHALL wrap modulo FIFO_DEPTH; count width SHALL be log2(FIFO_DEPTH)+1.
REQ-026 Non-decoded cpu_we cycles SHALL have no effect.

Reset
REQ-027 On map_rst: queue empty, pointers 0, gap counter 0, idx_latch 0, ovf 0, all shadow registers 0, reg_valid 0.
REQ-028 map_rst asserted mid-transfer SHALL discard queued entries; a pending reg_valid SHALL drop in the cycle after reset is sampled; map_rst has priority over cpu_we and reg_ready.

Structure
REQ-029 Decode masks/addresses (16'hF030, 16'h9010, 16'h9030) and the valid-index predicate SHALL reside in a shared opll_pkg package.
REQ-030 Queue SHALL be a separate sub-module sync_fifo (parameterised width 14, depth FIFO_DEPTH, push/pop/full/empty/count).
REQ-031 Shadow file SHALL be 64x8 registers, indexed directly by 6-bit index.

Verification
REQ-032 Write $9010=0x10, $9030=0xAB, reg_ready=1 -> one pop reg_addr=0x10, reg_data=0xAB; ss_addr=0x10 reads 0xAB.
REQ-033 Five data writes back-to-back, reg_ready=0, depth 4 -> 4 queued, ovf=1, shadow holds 5th value; release ready -> 4 pops spaced exactly 84 cycles.
REQ-034 Full queue, push coincident with pop -> count stays 4, ovf stays 0, pushed entry emerges last.
REQ-035 Index 0x0A then data 0x55 -> no reg_valid, shadow[0x0A]=0, ovf=0.
REQ-036 Queue holding 3 entries, gap counter at 40, assert map_rst one cycle -> reg_valid=0, queue empty, ovf=0, ss_rdat=0 for all indices; next write pops after 1 cycle with no gap.
REQ-037 Write to $9011 and $9031 (mask aliases) -> behave as $9010/$9030; write to $9020 -> ignored.
